// File: rtl/inst_loader.sv
// inst_loader: boot-time program loader for the instruction memory.
// Takes a 16-bit big-endian word count and then a byte stream over a
// valid/ready handshake. It packs the bytes into big-endian 32-bit words
// and writes them to consecutive word addresses starting at BASE_ADDR.
// cpu_hold keeps the CPU frozen while a load is in progress.
// Optional feature: define INST_LOADER_CHECKSUM_EN to enable a trailing XOR
// checksum byte.
module inst_loader #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        st_idle,
        st_len_hi,
        st_len_lo,
        st_data,
        st_write,
        st_csum,
        st_done
    } state_t;

    // The largest legal word count is the full memory depth. The limit is
    // 33 bits wide so the comparison stays exact for any ADDR_W up to 32.
    localparam logic [32:0] LEN_LIMIT = 33'd1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t      state;
    state_t      state_n;
    logic [7:0]  count_hi;
    logic [15:0] remain;
    logic [15:0] len_full;
    logic        len_bad;
    logic [1:0]  idx;
    logic [23:0] word;
    logic        xfer;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]  csum_acc;
`endif

    assign xfer     = in_valid & in_ready;
    assign len_full = {count_hi, in_data};
    assign len_bad  = ({17'd0, len_full} > LEN_LIMIT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= st_idle;
        else        state <= state_n;
    end

    // Next-state logic. Once the last word has been written (or the count is
    // zero), the FSM goes to the checksum byte if that feature is built in,
    // and otherwise goes straight to DONE.
    always_comb begin
        state_n = state;
        case (state)
            st_idle:   if (start) state_n = st_len_hi;
            st_len_hi: if (xfer) state_n = st_len_lo;
            st_len_lo: begin
                if (xfer) begin
                    if (len_full == 16'd0) begin
`ifdef INST_LOADER_CHECKSUM_EN
                        state_n = st_csum;
`else
                        state_n = st_done;
`endif
                    end else if (len_bad) begin
                        state_n = st_done;
                    end else begin
                        state_n = st_data;
                    end
                end
            end
            st_data:   if (xfer && idx == 2'd3) state_n = st_write;
            st_write: begin
                if (remain == 16'd1) begin
`ifdef INST_LOADER_CHECKSUM_EN
                    state_n = st_csum;
`else
                    state_n = st_done;
`endif
                end else begin
                    state_n = st_data;
                end
            end
            st_csum:   if (xfer) state_n = st_done;
            st_done:   state_n = st_idle;
            default:   state_n = st_idle;
        endcase
    end

    // Outputs are registered from the next state, so in_ready never depends
    // combinationally on in_valid. The datapath updates on the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= 32'd0;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            count_hi  <= 8'd0;
            remain    <= 16'd0;
            idx       <= 2'd0;
            word      <= 24'd0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_acc  <= 8'd0;
`endif
        end else begin
            in_ready <= (state_n == st_len_hi) || (state_n == st_len_lo) ||
                        (state_n == st_data)   || (state_n == st_csum);
            mem_we   <= (state_n == st_write);
            done     <= (state_n == st_done);
            cpu_hold <= (state_n != st_idle);
            case (state)
                st_idle: begin
                    if (start) begin
                        err      <= 1'b0;
                        mem_addr <= BASE_ADDR;
                        idx      <= 2'd0;
                        word     <= 24'd0;
`ifdef INST_LOADER_CHECKSUM_EN
                        csum_acc <= 8'd0;
`endif
                    end
                end
                st_len_hi: begin
                    if (xfer) count_hi <= in_data;
                end
                st_len_lo: begin
                    if (xfer) begin
                        remain <= len_full;
                        if (len_full != 16'd0 && len_bad) err <= 1'b1;
                    end
                end
                st_data: begin
                    if (xfer) begin
                        word <= {word[15:0], in_data};
                        idx  <= idx + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
                        csum_acc <= csum_acc ^ in_data;
`endif
                        if (idx == 2'd3) mem_wdata <= {word, in_data};
                    end
                end
                st_write: begin
                    mem_addr <= mem_addr + ADDR_ONE;
                    remain   <= remain - 16'd1;
                end
                st_csum: begin
`ifdef INST_LOADER_CHECKSUM_EN
                    if (xfer && in_data != csum_acc) err <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
